// File: rtl/rr_arbiter.sv
// Round-robin N-input arbiter with registered one-hot grants, stall-hold and
// burst locking. The grant is held while the downstream is not ready, and is
// released or handed on when a transfer (grant_valid_OUT && grant_ready_IN)
// completes.
// Optional build macro ARB_FIXED_PRIO_EN adds prio_mode_IN. When that input is
// high, selection picks the highest-indexed request instead of using ptr.
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic             clock_IN,
  input  logic             reset_n_IN,
`ifdef ARB_FIXED_PRIO_EN
  input  logic             prio_mode_IN,
`endif
  input  logic [N_REQ-1:0] requests_IN,
  input  logic [N_REQ-1:0] lock_IN,
  input  logic             grant_ready_IN,
  output logic [N_REQ-1:0] grants_OUT,
  output logic             grant_valid_OUT,
  output logic [IDX_W-1:0] grant_index_OUT
);

  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t           state;
  logic [N_REQ-1:0] grants;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] g;
  logic [IDX_W-1:0] ptr_adv;
  logic [IDX_W-1:0] pick_cur;
  logic [IDX_W-1:0] pick_adv;
  logic             any_req;

  // First asserted request searching upward from base, wrapping modulo N_REQ
  function automatic logic [IDX_W-1:0] rr_select(input logic [N_REQ-1:0] req,
                                                 input logic [IDX_W-1:0] base);
    logic [IDX_W-1:0] win;
    logic             found;
    int               k;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      k = (int'(base) + i) % N_REQ;
      if (!found && req[k]) begin
        win   = IDX_W'(k);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // Legacy ordering: the highest-indexed asserted request wins
  function automatic logic [IDX_W-1:0] fixed_select(input logic [N_REQ-1:0] req);
    logic [IDX_W-1:0] win;
    win = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req[i]) win = IDX_W'(i);
    end
    return win;
  endfunction

  function automatic logic [IDX_W-1:0] select(input logic [N_REQ-1:0] req,
                                              input logic [IDX_W-1:0] base);
`ifdef ARB_FIXED_PRIO_EN
    if (prio_mode_IN) return fixed_select(req);
`endif
    return rr_select(req, base);
  endfunction

  // Index of the currently granted bit, encoded from the registered vector
  always_comb begin
    g = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grants[i]) g = IDX_W'(i);
    end
  end

  // Candidate winners for the current pointer and for the advanced pointer
  always_comb begin
    any_req  = |requests_IN;
    ptr_adv  = (g == LAST_IDX) ? '0 : g + 1'b1;
    pick_cur = select(requests_IN, ptr);
    pick_adv = select(requests_IN, ptr_adv);
  end

  // Arbitration FSM: grant register, round-robin pointer and lock tracking
  always_ff @(posedge clock_IN or negedge reset_n_IN) begin
    if (!reset_n_IN) begin
      state  <= IDLE;
      grants <= '0;
      ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grants <= ONE_HOT0 << pick_cur;
            state  <= GRANT;
          end
        end
        GRANT, LOCKED: begin
          if (grant_ready_IN) begin
            // Transfer completes; keep the grant only for a live burst
            if (lock_IN[g] && requests_IN[g]) begin
              state <= LOCKED;
            end else begin
              ptr <= ptr_adv;
              if (any_req) begin
                grants <= ONE_HOT0 << pick_adv;
                state  <= GRANT;
              end else begin
                grants <= '0;
                state  <= IDLE;
              end
            end
          end else if (!requests_IN[g]) begin
            // Withdrawal: a burst owner still counts as served, a plain
            // grant does not, so only the former moves the pointer
            if (state == LOCKED) ptr <= ptr_adv;
            if (any_req) begin
              grants <= ONE_HOT0 << ((state == LOCKED) ? pick_adv : pick_cur);
              state  <= GRANT;
            end else begin
              grants <= '0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          grants <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign grants_OUT      = grants;
  assign grant_valid_OUT = |grants;
  assign grant_index_OUT = g;

endmodule

// File: tb/tb_rr_arbiter.sv
// Testbench for rr_arbiter: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_rr_arbiter;

  localparam int N = 4;

  logic         clk;
  logic         reset_n;
  logic [N-1:0] requests;
  logic [N-1:0] lock;
  logic         grant_ready;
  logic [N-1:0] grants;
  logic         grant_valid;
  logic [1:0]   grant_index;
`ifdef ARB_FIXED_PRIO_EN
  logic         prio_mode;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  // Model state: granted requester (-1 = none), pointer, burst flag
  int mg;
  int mptr;
  bit mlocked;

  rr_arbiter #(.N_REQ(N)) dut (
    .clock_IN        (clk),
    .reset_n_IN      (reset_n),
`ifdef ARB_FIXED_PRIO_EN
    .prio_mode_IN    (prio_mode),
`endif
    .requests_IN     (requests),
    .lock_IN         (lock),
    .grant_ready_IN  (grant_ready),
    .grants_OUT      (grants),
    .grant_valid_OUT (grant_valid),
    .grant_index_OUT (grant_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit fixed_mode();
`ifdef ARB_FIXED_PRIO_EN
    return prio_mode;
`else
    return 1'b0;
`endif
  endfunction

  // Winner: walk the search order and return the first requester present
  function automatic int pick(input logic [N-1:0] req, input int p, input bit fixed);
    int order[$];
    if (fixed) for (int k = N - 1; k >= 0; k--) order.push_back(k);
    else       for (int k = 0; k < N; k++)      order.push_back((p + k) % N);
    foreach (order[j]) if (req[order[j]]) return order[j];
    return -1;
  endfunction

  task automatic model_reset();
    mg      = -1;
    mptr    = 0;
    mlocked = 1'b0;
  endtask

  // Apply the arbitration rules for one rising edge with the current inputs
  task automatic model_step();
    bit fx;
    fx = fixed_mode();
    if (mg < 0) begin
      mg      = pick(requests, mptr, fx);
      mlocked = 1'b0;
    end else if (grant_ready) begin
      if (lock[mg] && requests[mg]) begin
        mlocked = 1'b1;
      end else begin
        mptr    = (mg + 1) % N;
        mlocked = 1'b0;
        mg      = pick(requests, mptr, fx);
      end
    end else if (!requests[mg]) begin
      if (mlocked) mptr = (mg + 1) % N;
      mlocked = 1'b0;
      mg      = pick(requests, mptr, fx);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: advance the model, then compare all outputs after the edge
  task automatic step(input string tag);
    logic [N-1:0] eg;
    model_step();
    eg = (mg < 0) ? '0 : (N'(1) << mg);
    @(posedge clk);
    #1;
    chk({tag, "_grants"}, 32'(grants), 32'(eg));
    chk({tag, "_valid"}, 32'(grant_valid), (mg < 0) ? 32'd0 : 32'd1);
    chk({tag, "_index"}, 32'(grant_index), (mg < 0) ? 32'd0 : 32'(mg));
  endtask

  task automatic async_reset_pulse(input string tag);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    chk({tag, "_rst_grants"}, 32'(grants), 32'd0);
    chk({tag, "_rst_valid"}, 32'(grant_valid), 32'd0);
    chk({tag, "_rst_index"}, 32'(grant_index), 32'd0);
    #2 reset_n = 1'b1;
  endtask

  logic [N-1:0] rot_exp [5];

  initial begin
    reset_n     = 1'b0;
    requests    = '0;
    lock        = '0;
    grant_ready = 1'b0;
`ifdef ARB_FIXED_PRIO_EN
    prio_mode   = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grants", 32'(grants), 32'd0);
    chk("reset_valid", 32'(grant_valid), 32'd0);
    chk("reset_index", 32'(grant_index), 32'd0);
    reset_n = 1'b1;

    // Rotation with all requesters active and ready held high
    rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0010; rot_exp[2] = 4'b0100;
    rot_exp[3] = 4'b1000; rot_exp[4] = 4'b0001;
    requests    = 4'b1111;
    grant_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step("rotate");
      chk("rotate_lit", 32'(grants), 32'(rot_exp[i]));
      chk("rotate_idx_lit", 32'(grant_index), 32'(i % 4));
    end

    // Stall on bit 2 for five cycles, then hand on to bit 3
    step("to_bit1");
    step("to_bit2");
    chk("stall_start_lit", 32'(grants), 32'h4);
    grant_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step("stall");
      chk("stall_lit", 32'(grants), 32'h4);
    end
    grant_ready = 1'b1;
    step("stall_release");
    chk("stall_release_lit", 32'(grants), 32'h8);

    // Burst lock on bit 0: four transfers, then bit 1, then pointer at 2
    requests = 4'b0011;
    step("burst_enter");
    chk("burst_enter_lit", 32'(grants), 32'h1);
    lock = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step("burst_hold");
      chk("burst_hold_lit", 32'(grants), 32'h1);
    end
    lock = 4'b0000;
    step("burst_exit");
    chk("burst_exit_lit", 32'(grants), 32'h2);
    step("burst_ptr2");
    chk("burst_ptr2_lit", 32'(grants), 32'h1);

    // Withdrawal of bit 1 while stalled: pointer must stay at 1
    requests = 4'b0110;
    step("wd_setup");
    chk("wd_setup_lit", 32'(grants), 32'h2);
    grant_ready = 1'b0;
    step("wd_hold");
    requests = 4'b0100;
    step("wd_drop");
    chk("wd_drop_lit", 32'(grants), 32'h4);
    requests = 4'b0011;
    step("wd_ptr1");
    chk("wd_ptr1_lit", 32'(grants), 32'h2);

    // Asynchronous reset while LOCKED, then a fresh grant to bit 3
    requests    = 4'b0010;
    lock        = 4'b0010;
    grant_ready = 1'b1;
    step("lock_enter");
    chk("lock_enter_lit", 32'(grants), 32'h2);
    #3 reset_n = 1'b0;
    #1;
    model_reset();
    chk("midlock_rst_grants", 32'(grants), 32'd0);
    chk("midlock_rst_valid", 32'(grant_valid), 32'd0);
    requests = 4'b1000;
    lock     = 4'b0000;
    #2 reset_n = 1'b1;
    step("post_reset");
    chk("post_reset_lit", 32'(grants), 32'h8);

`ifdef ARB_FIXED_PRIO_EN
    // Fixed priority: bit 2 beats bit 0 until it drops
    prio_mode = 1'b1;
    requests  = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      step("fixed");
      chk("fixed_lit", 32'(grants), 32'h4);
    end
    requests = 4'b0001;
    step("fixed_drop");
    chk("fixed_drop_lit", 32'(grants), 32'h1);
    prio_mode = 1'b0;
`endif

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      requests    = N'($urandom);
      lock        = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      grant_ready = ($urandom_range(0, 3) != 0);
`ifdef ARB_FIXED_PRIO_EN
      prio_mode   = ($urandom_range(0, 4) == 0);
`endif
      if ($urandom_range(0, 59) == 0) async_reset_pulse("rand");
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
